jk_cmd_driver: RTL



---
 rtl/jk_cmd_driver_if.sv | 39 +++
 rtl/jk_cmd_driver.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_driver_if.sv
// Command/bank interface for jk_cmd_driver.
// The mismatch status bus exists only when JK_CMD_DRIVER_STATUS_EN is defined.
interface jk_cmd_driver_if #(
  parameter int N = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_mask;
  logic [N-1:0] q_fb;
  logic [N-1:0] j;
  logic [N-1:0] k;
  logic         busy;
  logic         done;
  logic         err;
`ifdef JK_CMD_DRIVER_STATUS_EN
  logic [N-1:0] mismatch;

  modport master (
    output cmd_valid, cmd_op, cmd_mask, q_fb,
    input  cmd_ready, j, k, busy, done, err, mismatch
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, q_fb,
    output cmd_ready, j, k, busy, done, err, mismatch
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_mask, q_fb,
    input  cmd_ready, j, k, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, q_fb,
    output cmd_ready, j, k, busy, done, err
  );
`endif
endinterface

// File: rtl/jk_cmd_driver.sv
// Sequencer that pulses J/K on a JK flip-flop bank and checks the q feedback.
// Optional mismatch status output: define JK_CMD_DRIVER_STATUS_EN.
module jk_cmd_driver #(
  parameter int N       = 8,
  parameter int TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst,
  jk_cmd_driver_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [N-1:0]     exp_r;
  logic [N-1:0]     j_r;
  logic [N-1:0]     k_r;
  logic [CNT_W-1:0] cnt_r;
  logic             done_r;
  logic             err_r;
  logic             cmd_ready_s;
  logic             busy_s;
  logic             match_s;
  logic             last_s;

  // Expected bank value after the command, relative to the snapshot qs.
  function automatic logic [N-1:0] calc_exp(input logic [1:0]   op,
                                             input logic [N-1:0] mask,
                                             input logic [N-1:0] qs);
    logic [N-1:0] r;
    r = qs;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        case (op)
          2'b00:   r[i] = qs[i];
          2'b01:   r[i] = 1'b0;
          2'b10:   r[i] = 1'b1;
          2'b11:   r[i] = ~qs[i];
          default: r[i] = qs[i];
        endcase
      end else begin
        r[i] = qs[i];
      end
    end
    return r;
  endfunction

  assign match_s = (bus.q_fb == exp_r);
  assign last_s  = (cnt_r == CNT_LAST);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_next_s = DRIVE;
        end else begin
          state_next_s = IDLE;
        end
      end
      DRIVE: state_next_s = CHECK;
      CHECK: begin
        if (match_s || last_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = CHECK;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    cmd_ready_s = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      IDLE:    cmd_ready_s = 1'b1;
      DRIVE:   busy_s      = 1'b1;
      CHECK:   busy_s      = 1'b1;
      default: cmd_ready_s = 1'b0;
    endcase
  end

  // Command capture, J/K pulse, CHECK counter and completion pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_r  <= {N{1'b0}};
      j_r    <= {N{1'b0}};
      k_r    <= {N{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.cmd_valid) begin
            exp_r <= calc_exp(bus.cmd_op, bus.cmd_mask, bus.q_fb);
            j_r   <= bus.cmd_mask & {N{bus.cmd_op[1]}};
            k_r   <= bus.cmd_mask & {N{bus.cmd_op[0]}};
          end
        end
        DRIVE: begin
          j_r   <= {N{1'b0}};
          k_r   <= {N{1'b0}};
          cnt_r <= {CNT_W{1'b0}};
        end
        CHECK: begin
          if (match_s) begin
            done_r <= 1'b1;
          end else if (last_s) begin
            err_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          j_r <= {N{1'b0}};
          k_r <= {N{1'b0}};
        end
      endcase
    end
  end

`ifdef JK_CMD_DRIVER_STATUS_EN
  logic [N-1:0] mismatch_r;

  // Bits still wrong at timeout; cleared when the next command is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch_r <= {N{1'b0}};
    end else if (state_r == IDLE && bus.cmd_valid) begin
      mismatch_r <= {N{1'b0}};
    end else if (state_r == CHECK && !match_s && last_s) begin
      mismatch_r <= bus.q_fb ^ exp_r;
    end
  end

  assign bus.mismatch = mismatch_r;
`endif

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.busy      = busy_s;
  assign bus.j         = j_r;
  assign bus.k         = k_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;

endmodule
